// File: rtl/pattern_player.sv
// Playback sequencer: walks a latched range of pattern buffers byte-by-byte and streams them out.
// Optional checksum output enabled by defining PATPLAY_CHECKSUM_EN.
module pattern_player #(
    parameter int BUFSIZE = 26,
    parameter int NOBUFS  = 7
) (
    input  logic       sclk,
    input  logic       nreset,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] first_buf,
    input  logic [2:0] last_buf,
    input  logic [4:0] len,
    input  logic       loop,
    output logic [2:0] rd_buf,
    output logic [4:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
`ifdef PATPLAY_CHECKSUM_EN
    output logic [7:0] checksum,
`endif
    output logic       done
);

    localparam logic [4:0] LEN_MAX = 5'(BUFSIZE);
    localparam logic [2:0] BUF_MAX = 3'(NOBUFS);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t     state_q;
    logic [2:0] first_q, last_q, rd_buf_q;
    logic [4:0] len_q, rd_addr_q;
    logic       loop_q, fin_q, out_valid_q, done_q;
    logic [7:0] out_byte_q;
    logic [2:0] adv_buf_d;
    logic [4:0] adv_addr_d;
    logic       at_end_d;
`ifdef PATPLAY_CHECKSUM_EN
    logic [7:0] chk_q;
`endif

    // Next read pointer; at_end_d marks the final byte of a non-loop run.
    always_comb begin
        adv_buf_d  = rd_buf_q;
        adv_addr_d = rd_addr_q + 5'd1;
        at_end_d   = 1'b0;
        if (rd_addr_q >= len_q) begin
            adv_addr_d = 5'd0;
            if (rd_buf_q != last_q)
                adv_buf_d = (rd_buf_q == BUF_MAX) ? 3'd0 : rd_buf_q + 3'd1;
            else begin
                adv_buf_d = first_q;
                at_end_d  = !loop_q;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (!nreset) begin
            state_q     <= IDLE;
            first_q     <= 3'd0;
            last_q      <= 3'd0;
            len_q       <= 5'd0;
            loop_q      <= 1'b0;
            rd_buf_q    <= 3'd0;
            rd_addr_q   <= 5'd0;
            fin_q       <= 1'b0;
            out_byte_q  <= 8'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PATPLAY_CHECKSUM_EN
            chk_q       <= 8'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        first_q   <= first_buf;
                        last_q    <= last_buf;
                        len_q     <= (len > LEN_MAX) ? LEN_MAX : len;
                        loop_q    <= loop;
                        rd_buf_q  <= first_buf;
                        rd_addr_q <= 5'd0;
                        fin_q     <= 1'b0;
`ifdef PATPLAY_CHECKSUM_EN
                        chk_q     <= 8'd0;
`endif
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_byte_q  <= rd_data;
                        out_valid_q <= 1'b1;
                        fin_q       <= at_end_d;
                        if (!at_end_d) begin
                            rd_buf_q  <= adv_buf_d;
                            rd_addr_q <= adv_addr_d;
                        end
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (stop) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (out_valid_q && out_ready) begin
`ifdef PATPLAY_CHECKSUM_EN
                        chk_q <= chk_q ^ out_byte_q;
`endif
                        if (fin_q) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            out_byte_q <= rd_data;
                            fin_q      <= at_end_d;
                            if (!at_end_d) begin
                                rd_buf_q  <= adv_buf_d;
                                rd_addr_q <= adv_addr_d;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_buf    = rd_buf_q;
    assign rd_addr   = rd_addr_q;
    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
`ifdef PATPLAY_CHECKSUM_EN
    assign checksum  = chk_q;
`endif

endmodule

// File: tb/tb_pattern_player.sv
// Scoreboard bench for pattern_player: random bank contents, random runs and handshake stalls,
// expected byte streams derived from the range/length rules; checksum checked if PATPLAY_CHECKSUM_EN.
module tb_pattern_player;

    logic       sclk = 1'b0;
    logic       nreset, start, stop, loop, out_ready;
    logic [2:0] first_buf, last_buf, rd_buf;
    logic [4:0] len, rd_addr;
    logic [7:0] rd_data, out_byte;
    logic       out_valid, busy, done;
`ifdef PATPLAY_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] bank [8][32];
    logic [7:0] exp_q [$];
    logic [7:0] exp_chk;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         run_loop  = 1'b0;
    bit         pend_done = 1'b0;
    bit         done_seen = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'd0;

    always #5 sclk = ~sclk;

    assign rd_data = bank[rd_buf][rd_addr];

    pattern_player #(.BUFSIZE(26), .NOBUFS(7)) dut (
        .sclk(sclk), .nreset(nreset), .start(start), .stop(stop),
        .first_buf(first_buf), .last_buf(last_buf), .len(len), .loop(loop),
        .rd_buf(rd_buf), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy),
`ifdef PATPLAY_CHECKSUM_EN
        .checksum(checksum),
`endif
        .done(done)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: consumes accepted bytes against the expected stream.
    always @(negedge sclk) begin
        if (pend_done) begin
            check("done_pulse", done, 1);
            check("done_busy_low", busy, 0);
            check("done_valid_low", out_valid, 0);
`ifdef PATPLAY_CHECKSUM_EN
            check("checksum", checksum, exp_chk);
`endif
            pend_done = 1'b0;
            done_seen = 1'b1;
        end else begin
            check("no_spurious_done", done, 0);
        end
        if (prev_stall) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_byte_held", out_byte, prev_byte);
        end
        if (nreset && !stop && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", out_byte, 32'hFFFF_FFFF);
            end else begin
                check("stream_byte", out_byte, exp_q.pop_front());
                if (exp_q.size() == 0 && !run_loop) pend_done = 1'b1;
            end
        end
        prev_stall = nreset && !stop && out_valid && !out_ready;
        prev_byte  = out_byte;
    end

    // abort: 0 = run to done, 1 = stop after n cycles, 2 = reset after n cycles.
    // rmode: 0 = ready always 1, 1 = random ready, 2 = ready pattern 1,0,0,1.
    task automatic run(input logic [2:0] f, input logic [2:0] l, input logic [4:0] ln,
                       input bit lp, input int rmode, input int abort, input int ncyc);
        int  lmax, nb, reps;
        bit  pulsed;
        bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        lmax = (ln > 26) ? 26 : int'(ln);
        nb   = int'(3'(l - f)) + 1;
        reps = lp ? 40 : 1;
        exp_chk = 8'd0;
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < nb; k++)
                for (int i = 0; i <= lmax; i++) begin
                    exp_q.push_back(bank[(int'(f) + k) % 8][i]);
                    exp_chk ^= bank[(int'(f) + k) % 8][i];
                end
        run_loop  = lp;
        done_seen = 1'b0;
        pulsed    = 1'b0;
        @(posedge sclk); #1;
        first_buf = f; last_buf = l; len = ln; loop = lp; start = 1'b1;
        out_ready = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0;
        first_buf = 3'($urandom); last_buf = 3'($urandom); len = 5'($urandom); loop = 1'($urandom);
        @(negedge sclk);
        check("load_busy", busy, 1);
        check("load_valid_low", out_valid, 0);
        for (int c = 0; c < 4000; c++) begin
            @(posedge sclk); #1;
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : pat[c % 4];
            if (c == 3 && busy && !pulsed) begin
                start = 1'b1; pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (abort != 0 && c == ncyc) break;
            if (abort == 0 && done_seen) break;
        end
        start = 1'b0;
        if (abort == 1) begin
            stop = 1'b1;
            out_ready = 1'b1;
            @(posedge sclk); #1;
            stop = 1'b0;
            exp_q.delete();
            @(negedge sclk);
            check("stop_valid_low", out_valid, 0);
            check("stop_busy_low", busy, 0);
        end else if (abort == 2) begin
            nreset = 1'b0;
            @(posedge sclk); #1;
            nreset = 1'b1;
            exp_q.delete();
            @(negedge sclk);
            check("rst_out_byte", out_byte, 0);
            check("rst_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_rd_buf", rd_buf, 0);
            check("rst_rd_addr", rd_addr, 0);
`ifdef PATPLAY_CHECKSUM_EN
            check("rst_checksum", checksum, 0);
`endif
        end else begin
            check("run_completed", done_seen, 1);
            check("queue_drained", exp_q.size(), 0);
            exp_q.delete();
        end
        run_loop = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
    endtask

    initial begin
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 32; i++)
                bank[b][i] = (b == 2) ? 8'(8'h20 + i) : 8'($urandom);
        nreset = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; out_ready = 1'b0;
        first_buf = 3'd0; last_buf = 3'd0; len = 5'd0;
        repeat (2) @(posedge sclk);
        #1 nreset = 1'b1;
        @(negedge sclk);
        check("reset_out_byte", out_byte, 0);
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_buf", rd_buf, 0);
        check("reset_rd_addr", rd_addr, 0);

        run(3'd2, 3'd2, 5'd3, 1'b0, 0, 0, 0);
        run(3'd6, 3'd1, 5'd0, 1'b0, 0, 0, 0);
        run(3'd3, 3'd4, 5'd31, 1'b0, 1, 0, 0);
        run(3'd5, 3'd5, 5'd6, 1'b0, 2, 0, 0);
        run(3'd0, 3'd1, 5'd1, 1'b1, 0, 1, 13);
        run(3'd7, 3'd2, 5'd9, 1'b1, 1, 1, 30);
        run(3'd1, 3'd3, 5'd20, 1'b0, 1, 2, 17);
        for (int t = 0; t < 6; t++)
            run(3'($urandom), 3'($urandom), 5'($urandom), 1'b0, 1, 0, 0);

        @(posedge sclk); #1;
        first_buf = 3'd1; last_buf = 3'd2; len = 5'd2; start = 1'b1; stop = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0; stop = 1'b0;
        @(negedge sclk);
        check("start_with_stop_idle", busy, 0);
        check("start_with_stop_no_valid", out_valid, 0);
        repeat (3) @(posedge sclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
